// File: rtl/lcd_pkg.sv
// Package for the LCD command/data byte-stream decoder.
// Contents: opcode constants, decoder FSM state type and the window
// parameter clamp helper shared by lcd_cmd_decoder.
package lcd_pkg;

    localparam logic [7:0] LCD_NOP     = 8'h00;
    localparam logic [7:0] LCD_SWRESET = 8'h01;
    localparam logic [7:0] LCD_SLPOUT  = 8'h11;
    localparam logic [7:0] LCD_DISPOFF = 8'h28;
    localparam logic [7:0] LCD_DISPON  = 8'h29;
    localparam logic [7:0] LCD_COLMOD  = 8'h3A;
    localparam logic [7:0] LCD_CASET   = 8'h2A;
    localparam logic [7:0] LCD_PASET   = 8'h2B;
    localparam logic [7:0] LCD_RAMWR   = 8'h2C;

    localparam logic [7:0] COLMOD_RESET = 8'h66;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLMOD,
        ST_CASET,
        ST_PASET,
        ST_RAM_HI,
        ST_RAM_LO
    } dec_state_t;

    // min(value, limit) reduced to a 9-bit coordinate.
    function automatic logic [8:0] clamp9(input logic [15:0] value, input int unsigned limit);
        if (32'(value) > limit) begin
            return 9'(limit);
        end
        return value[8:0];
    endfunction

endpackage

// File: rtl/lcd_window_cursor.sv
// Column/page window registers and pixel write cursor.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   win_reset             restore the full-panel window
//   load_col / load_page  load SC/EC or SP/EP from load_start / load_end
//   restart               cursor := (SC, SP)
//   advance               step cursor one pixel in raster order inside the window
//   x, y                  current cursor
//   last_pixel            cursor sits on (EC, EP)
//   win_valid             SC <= EC and SP <= EP
module lcd_window_cursor #(
    parameter int unsigned MAX_COL  = 239,
    parameter int unsigned MAX_PAGE = 319
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       win_reset,
    input  logic       load_col,
    input  logic       load_page,
    input  logic [8:0] load_start,
    input  logic [8:0] load_end,
    input  logic       restart,
    input  logic       advance,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       last_pixel,
    output logic       win_valid
);

    logic [8:0] sc_q, ec_q, sp_q, ep_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q <= '0;
            ec_q <= 9'(MAX_COL);
            sp_q <= '0;
            ep_q <= 9'(MAX_PAGE);
        end else if (win_reset) begin
            sc_q <= '0;
            ec_q <= 9'(MAX_COL);
            sp_q <= '0;
            ep_q <= 9'(MAX_PAGE);
        end else begin
            if (load_col) begin
                sc_q <= load_start;
                ec_q <= load_end;
            end
            if (load_page) begin
                sp_q <= load_start;
                ep_q <= load_end;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            x <= sc_q;
            y <= sp_q;
        end else if (advance) begin
            if (x < ec_q) begin
                x <= x + 9'd1;
            end else begin
                x <= sc_q;
                y <= (y < ep_q) ? y + 9'd1 : sp_q;
            end
        end
    end

    assign last_pixel = (x == ec_q) && (y == ep_q);
    assign win_valid  = (sc_q <= ec_q) && (sp_q <= ep_q);

endmodule

// File: rtl/lcd_cmd_decoder.sv
// Panel-side decoder for the 8-bit LCD command/data byte stream.
// Decodes opcodes and parameters, keeps window/cursor/mode flags and
// re-assembles 16-bit pixels into one pixel write per byte pair.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, d, dcx       byte strobe, bus byte, 0=command / 1=data
//   pix_valid, pix_x, pix_y, pix_color, frame_done   pixel write output
//   sleep_out, display_on, colmod                    mode flags
//   busy, err_cmd, err_timing                        status / protocol errors
// Build option: LCD_DEC_TIMING_CHECK_EN enables the post-SWRESET/SLPOUT wait
// counter; without it busy and err_timing are tied to 0.
module lcd_cmd_decoder #(
    parameter int unsigned MAX_COL     = 239,
    parameter int unsigned MAX_PAGE    = 319,
    parameter int unsigned WAIT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  d,
    input  logic        dcx,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        frame_done,
    output logic        sleep_out,
    output logic        display_on,
    output logic [7:0]  colmod,
    output logic        busy,
    output logic        err_cmd,
    output logic        err_timing
);
    import lcd_pkg::*;

    dec_state_t  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] start_q, start_d;
    logic [7:0]  hi_q, hi_d;
    // Set after RAMWR on an invalid window: data is silently dropped.
    logic        drop_q, drop_d;

    logic        sleep_d, disp_d, pix_valid_d, frame_d, err_cmd_d;
    logic [7:0]  colmod_d;
    logic [8:0]  pix_x_d, pix_y_d;
    logic [15:0] pix_color_d;

    logic        win_reset, load_col, load_page, restart, advance, reload;
    logic [8:0]  load_start, load_end;
    logic [8:0]  cur_x, cur_y;
    logic        last_pixel, win_valid;
    int unsigned limit;

    lcd_window_cursor #(
        .MAX_COL  (MAX_COL),
        .MAX_PAGE (MAX_PAGE)
    ) u_window_cursor (
        .clk        (clk),
        .rst        (rst),
        .win_reset  (win_reset),
        .load_col   (load_col),
        .load_page  (load_page),
        .load_start (load_start),
        .load_end   (load_end),
        .restart    (restart),
        .advance    (advance),
        .x          (cur_x),
        .y          (cur_y),
        .last_pixel (last_pixel),
        .win_valid  (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = start_q;
        hi_d        = hi_q;
        drop_d      = drop_q;
        sleep_d     = sleep_out;
        disp_d      = display_on;
        colmod_d    = colmod;
        pix_valid_d = 1'b0;
        frame_d     = 1'b0;
        err_cmd_d   = 1'b0;
        pix_x_d     = pix_x;
        pix_y_d     = pix_y;
        pix_color_d = pix_color;
        win_reset   = 1'b0;
        load_col    = 1'b0;
        load_page   = 1'b0;
        restart     = 1'b0;
        advance     = 1'b0;
        reload      = 1'b0;
        limit       = (state_q == ST_CASET) ? MAX_COL : MAX_PAGE;
        load_start  = clamp9(start_q, limit);
        load_end    = clamp9({hi_q, d}, limit);

        if (wr_en) begin
            if (!dcx) begin
                // Any command aborts pending parameters or a half pixel.
                state_d = ST_IDLE;
                idx_d   = '0;
                drop_d  = 1'b0;
                case (d)
                    LCD_NOP: ;
                    LCD_SWRESET: begin
                        sleep_d   = 1'b0;
                        disp_d    = 1'b0;
                        colmod_d  = COLMOD_RESET;
                        win_reset = 1'b1;
                        reload    = 1'b1;
                    end
                    LCD_SLPOUT: begin
                        sleep_d = 1'b1;
                        reload  = 1'b1;
                    end
                    LCD_DISPOFF: disp_d  = 1'b0;
                    LCD_DISPON:  disp_d  = 1'b1;
                    LCD_COLMOD:  state_d = ST_COLMOD;
                    LCD_CASET:   state_d = ST_CASET;
                    LCD_PASET:   state_d = ST_PASET;
                    LCD_RAMWR: begin
                        if (win_valid) begin
                            restart = 1'b1;
                            state_d = ST_RAM_HI;
                        end else begin
                            err_cmd_d = 1'b1;
                            drop_d    = 1'b1;
                        end
                    end
                    default: err_cmd_d = 1'b1;
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: err_cmd_d = !drop_q;
                    ST_COLMOD: begin
                        colmod_d = d;
                        state_d  = ST_IDLE;
                    end
                    ST_CASET, ST_PASET: begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0: hi_d = d;
                            2'd1: start_d = {hi_q, d};
                            2'd2: hi_d = d;
                            default: begin
                                load_col  = (state_q == ST_CASET);
                                load_page = (state_q == ST_PASET);
                                state_d   = ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAM_HI: begin
                        hi_d    = d;
                        state_d = ST_RAM_LO;
                    end
                    ST_RAM_LO: begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = cur_x;
                        pix_y_d     = cur_y;
                        pix_color_d = {hi_q, d};
                        frame_d     = last_pixel;
                        advance     = 1'b1;
                        state_d     = ST_RAM_HI;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            start_q    <= '0;
            hi_q       <= '0;
            drop_q     <= 1'b0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
            colmod     <= COLMOD_RESET;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err_cmd    <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            start_q    <= start_d;
            hi_q       <= hi_d;
            drop_q     <= drop_d;
            sleep_out  <= sleep_d;
            display_on <= disp_d;
            colmod     <= colmod_d;
            pix_valid  <= pix_valid_d;
            frame_done <= frame_d;
            err_cmd    <= err_cmd_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
            pix_color  <= pix_color_d;
        end
    end

`ifdef LCD_DEC_TIMING_CHECK_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= '0;
            err_timing <= 1'b0;
        end else begin
            if (reload) begin
                wait_q <= CNT_W'(WAIT_CYCLES);
            end else if (wait_q != '0) begin
                wait_q <= wait_q - CNT_W'(1);
            end
            err_timing <= wr_en && busy;
        end
    end

    assign busy = (wait_q != '0);
`else
    logic unused_wait;
    assign unused_wait = ^{WAIT_CYCLES, reload};
    assign busy        = 1'b0;
    assign err_timing  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Self-checking bench for lcd_cmd_decoder: directed scenarios plus a
// randomized byte stream checked against a behavioural display model.
module tb_lcd_cmd_decoder;

    localparam int MAX_COL  = 239;
    localparam int MAX_PAGE = 319;
    localparam int TB_WAIT  = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        dcx = 1'b0;
    logic        pix_valid, frame_done, sleep_out, display_on, busy, err_cmd, err_timing;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_color;
    logic [7:0]  colmod;

    int n_vec = 0;
    int n_bad = 0;

    lcd_cmd_decoder #(
        .MAX_COL     (MAX_COL),
        .MAX_PAGE    (MAX_PAGE),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .d          (d),
        .dcx        (dcx),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .frame_done (frame_done),
        .sleep_out  (sleep_out),
        .display_on (display_on),
        .colmod     (colmod),
        .busy       (busy),
        .err_cmd    (err_cmd),
        .err_timing (err_timing)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_COLMOD = 1, M_CASET = 2, M_PASET = 3, M_RAM = 4, M_DROP = 5;
    int         mode, sc, ec, sp, ep, cx, cy;
    logic [7:0] pq[$];
    logic [7:0] m_colmod;
    bit         m_disp, m_sleep;
    bit         e_pv, e_fd, e_err;
    int         e_x, e_y;
    logic [15:0] e_col;

    task automatic model_reset();
        mode = M_IDLE; sc = 0; ec = MAX_COL; sp = 0; ep = MAX_PAGE; cx = 0; cy = 0;
        pq.delete(); m_colmod = 8'h66; m_disp = 0; m_sleep = 0;
    endtask

    task automatic model_step(input bit dc, input logic [7:0] b);
        int s, e, lim;
        e_pv = 0; e_fd = 0; e_err = 0;
        if (!dc) begin
            pq.delete();
            mode = M_IDLE;
            case (b)
                8'h00: ;
                8'h01: begin
                    m_sleep = 0; m_disp = 0; m_colmod = 8'h66;
                    sc = 0; ec = MAX_COL; sp = 0; ep = MAX_PAGE;
                end
                8'h11: m_sleep = 1;
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h3A: mode = M_COLMOD;
                8'h2A: mode = M_CASET;
                8'h2B: mode = M_PASET;
                8'h2C: begin
                    if (sc <= ec && sp <= ep) begin
                        cx = sc; cy = sp; mode = M_RAM;
                    end else begin
                        e_err = 1; mode = M_DROP;
                    end
                end
                default: e_err = 1;
            endcase
        end else begin
            case (mode)
                M_IDLE: e_err = 1;
                M_COLMOD: begin m_colmod = b; mode = M_IDLE; end
                M_CASET, M_PASET: begin
                    pq.push_back(b);
                    if (pq.size() == 4) begin
                        lim = (mode == M_CASET) ? MAX_COL : MAX_PAGE;
                        s = pq[0] * 256 + pq[1];
                        e = pq[2] * 256 + pq[3];
                        if (s > lim) s = lim;
                        if (e > lim) e = lim;
                        if (mode == M_CASET) begin sc = s; ec = e; end
                        else begin sp = s; ep = e; end
                        pq.delete();
                        mode = M_IDLE;
                    end
                end
                M_RAM: begin
                    pq.push_back(b);
                    if (pq.size() == 2) begin
                        e_pv = 1; e_x = cx; e_y = cy; e_col = {pq[0], pq[1]};
                        e_fd = (cx == ec) && (cy == ep);
                        if (cx < ec) cx++;
                        else begin
                            cx = sc;
                            if (cy < ep) cy++; else cy = sp;
                        end
                        pq.delete();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one byte at the current falling edge; returns at the next falling
    // edge, where the registered response to that byte is visible.
    task automatic send(input bit dc, input logic [7:0] b);
        wr_en = 1'b1; dcx = dc; d = b;
        model_step(dc, b);
        @(negedge clk);
        wr_en = 1'b0; dcx = 1'b0; d = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_reset();
        n_vec++;
        if ({pix_valid, pix_x, pix_y, pix_color, frame_done, sleep_out, display_on,
             busy, err_cmd, err_timing} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got pv=%b x=%0d y=%0d c=%h fd=%b so=%b don=%b bsy=%b ec=%b et=%b want all 0",
                     pix_valid, pix_x, pix_y, pix_color, frame_done, sleep_out, display_on,
                     busy, err_cmd, err_timing);
        end
        n_vec++;
        if (colmod !== 8'h66) begin
            n_bad++; $display("FAIL reset_colmod: got %h want 66", colmod);
        end
        send(0, 8'h2C); send(1, 8'hF8); send(1, 8'h00);
        n_vec++;
        if ({pix_valid, pix_x, pix_y, pix_color} !== {1'b1, 9'd0, 9'd0, 16'hF800}) begin
            n_bad++;
            $display("FAIL reset_first_pixel: got v=%b (%0d,%0d,%h) want v=1 (0,0,f800)",
                     pix_valid, pix_x, pix_y, pix_color);
        end
    endtask

    task automatic test_window();
        logic [7:0]  seq[6];
        logic [8:0]  wx[3];
        logic [15:0] wc[3];
        logic [2:0]  wfd;
        seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        wx  = '{9'd10, 9'd11, 9'd10};
        wc  = '{16'h1234, 16'h5678, 16'h9ABC};
        wfd = 3'b010;
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h0B);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h05);
        send(0, 8'h2C);
        for (int i = 0; i < 3; i++) begin
            send(1, seq[2*i]);
            n_vec++;
            if (pix_valid !== 1'b0) begin
                n_bad++; $display("FAIL window_hi_byte%0d: got pix_valid=%b want 0", i, pix_valid);
            end
            send(1, seq[2*i+1]);
            n_vec++;
            if ({pix_valid, pix_x, pix_y, pix_color, frame_done} !==
                {1'b1, wx[i], 9'd5, wc[i], wfd[i]}) begin
                n_bad++;
                $display("FAIL window_pixel%0d: got v=%b (%0d,%0d,%h) fd=%b want v=1 (%0d,5,%h) fd=%b",
                         i, pix_valid, pix_x, pix_y, pix_color, frame_done, wx[i], wc[i], wfd[i]);
            end
        end
    endtask

    task automatic test_clamp();
        logic [8:0] wx[3];
        logic [2:0] wfd;
        wx  = '{9'd238, 9'd239, 9'd238};
        wfd = 3'b010;
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'hEE); send(1, 8'h00); send(1, 8'hF0);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
        send(0, 8'h2C);
        for (int i = 0; i < 3; i++) begin
            send(1, 8'hAA); send(1, 8'(i));
            n_vec++;
            if ({pix_valid, pix_x, pix_y, frame_done} !== {1'b1, wx[i], 9'd0, wfd[i]}) begin
                n_bad++;
                $display("FAIL clamp_pixel%0d: got v=%b (%0d,%0d) fd=%b want v=1 (%0d,0) fd=%b",
                         i, pix_valid, pix_x, pix_y, frame_done, wx[i], wfd[i]);
            end
        end
        // SC > EC: RAMWR must flag and drop its data.
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h14); send(1, 8'h00); send(1, 8'h0A);
        send(0, 8'h2C);
        n_vec++;
        if (err_cmd !== 1'b1) begin
            n_bad++; $display("FAIL invalid_window_err: got err_cmd=%b want 1", err_cmd);
        end
        for (int i = 0; i < 4; i++) begin
            send(1, 8'h11);
            n_vec++;
            if (pix_valid !== 1'b0) begin
                n_bad++; $display("FAIL invalid_window_drop%0d: got pix_valid=%b want 0", i, pix_valid);
            end
        end
    endtask

    task automatic test_abort();
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h03); send(1, 8'h00); send(1, 8'hEF);
        send(0, 8'h2C); send(1, 8'hF8); send(0, 8'h29);
        n_vec++;
        if ({pix_valid, display_on} !== 2'b01) begin
            n_bad++;
            $display("FAIL abort_half_pixel: got pix_valid=%b display_on=%b want 0 1", pix_valid, display_on);
        end
        send(1, 8'h12);
        n_vec++;
        if ({err_cmd, pix_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL stray_data: got err_cmd=%b pix_valid=%b want 1 0", err_cmd, pix_valid);
        end
        send(0, 8'h55);
        n_vec++;
        if (err_cmd !== 1'b1) begin
            n_bad++; $display("FAIL bad_opcode: got err_cmd=%b want 1", err_cmd);
        end
        send(0, 8'h28);
        n_vec++;
        if ({err_cmd, display_on} !== 2'b00) begin
            n_bad++; $display("FAIL dispoff: got err_cmd=%b display_on=%b want 0 0", err_cmd, display_on);
        end
    endtask

    task automatic test_colmod_swreset();
        send(0, 8'h29);
        send(0, 8'h3A); send(1, 8'h55);
        n_vec++;
        if (colmod !== 8'h55) begin
            n_bad++; $display("FAIL colmod_write: got %h want 55", colmod);
        end
        send(0, 8'h01);
        n_vec++;
        if ({colmod, display_on, sleep_out} !== {8'h66, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL swreset_flags: got colmod=%h don=%b so=%b want 66 0 0", colmod, display_on, sleep_out);
        end
`ifdef LCD_DEC_TIMING_CHECK_EN
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL swreset_busy: got %b want 1", busy);
        end
`endif
        idle(TB_WAIT + 10);
        send(0, 8'h2C); send(1, 8'h07); send(1, 8'hE0);
        n_vec++;
        if ({pix_valid, pix_x, pix_y, pix_color, err_timing} !== {1'b1, 9'd0, 9'd0, 16'h07E0, 1'b0}) begin
            n_bad++;
            $display("FAIL swreset_window: got v=%b (%0d,%0d,%h) et=%b want v=1 (0,0,07e0) et=0",
                     pix_valid, pix_x, pix_y, pix_color, err_timing);
        end
    endtask

    task automatic gen_window(input logic [7:0] op, inout logic [7:0] q[$]);
        logic [15:0] s, e;
        int r;
        s = 16'($urandom_range(0, 20));
        r = $urandom_range(0, 5);
        if (r == 0)      e = (s > 0) ? s - 16'd1 : 16'd0;
        else if (r == 1) e = 16'hFF00 | 16'($urandom_range(0, 255));
        else             e = s + 16'($urandom_range(0, 3));
        q.push_back(op);
        q.push_back(s[15:8]); q.push_back(s[7:0]); q.push_back(e[15:8]); q.push_back(e[7:0]);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        bit         qd[$];
        logic [7:0] misc[6];
        int         kind, n;
        misc = '{8'h00, 8'h28, 8'h29, 8'h55, 8'hFF, 8'h3B};
        for (int t = 0; t < 120; t++) begin
            q.delete(); qd.delete();
            kind = $urandom_range(0, 9);
            case (kind)
                0: gen_window(8'h2A, q);
                1: gen_window(8'h2B, q);
                2, 3, 4, 5: begin
                    q.push_back(8'h2C);
                    n = $urandom_range(0, 9);
                    for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
                end
                6: begin q.push_back(8'h3A); q.push_back(8'($urandom_range(0, 255))); end
                7: q.push_back(misc[$urandom_range(0, 5)]);
                8: q.push_back(8'($urandom_range(0, 255)));
                default: begin
                    q.push_back(8'h2A);
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
                end
            endcase
            // First byte of each transaction is a command except for stray data.
            for (int k = 0; k < q.size(); k++) qd.push_back(!(k == 0 && kind != 8));
            for (int k = 0; k < q.size(); k++) begin
                send(qd[k], q[k]);
                n_vec++;
                if (pix_valid !== e_pv) begin
                    n_bad++; $display("FAIL rnd_pix_valid t%0d: got %b want %b", t, pix_valid, e_pv);
                end
                if (e_pv) begin
                    n_vec++;
                    if ({pix_x, pix_y, pix_color} !== {9'(e_x), 9'(e_y), e_col}) begin
                        n_bad++;
                        $display("FAIL rnd_pixel t%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                 t, pix_x, pix_y, pix_color, e_x, e_y, e_col);
                    end
                end
                n_vec++;
                if ({frame_done, err_cmd, err_timing} !== {e_fd, e_err, 1'b0}) begin
                    n_bad++;
                    $display("FAIL rnd_pulses t%0d: got fd=%b ec=%b et=%b want %b %b 0",
                             t, frame_done, err_cmd, err_timing, e_fd, e_err);
                end
                n_vec++;
                if ({colmod, display_on} !== {m_colmod, m_disp}) begin
                    n_bad++;
                    $display("FAIL rnd_flags t%0d: got colmod=%h don=%b want %h %b",
                             t, colmod, display_on, m_colmod, m_disp);
                end
            end
        end
    endtask

    task automatic test_timing();
        send(0, 8'h11);
        n_vec++;
        if (sleep_out !== 1'b1) begin
            n_bad++; $display("FAIL slpout_flag: got %b want 1", sleep_out);
        end
`ifdef LCD_DEC_TIMING_CHECK_EN
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL slpout_busy: got %b want 1", busy);
        end
        idle(99);
        send(0, 8'h00);
        n_vec++;
        if ({err_timing, sleep_out} !== 2'b11) begin
            n_bad++; $display("FAIL early_byte: got err_timing=%b sleep_out=%b want 1 1", err_timing, sleep_out);
        end
        idle(TB_WAIT - 100);
        send(0, 8'h00);
        n_vec++;
        if ({err_timing, busy} !== 2'b00) begin
            n_bad++; $display("FAIL late_byte: got err_timing=%b busy=%b want 0 0", err_timing, busy);
        end
`else
        idle(99);
        send(0, 8'h00);
        n_vec++;
        if ({err_timing, busy, sleep_out} !== 3'b001) begin
            n_bad++;
            $display("FAIL no_timing_check: got et=%b busy=%b so=%b want 0 0 1", err_timing, busy, sleep_out);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_window();
        test_clamp();
        test_abort();
        test_colmod_swreset();
        test_random();
        test_timing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
